// File: rtl/mario_obj_dma.sv
// mario_obj_dma
//   Sprite-list DMA controller for the object pipeline. On every falling edge
//   of vertical blank (with DMA enabled) it requests the Z80 bus, copies
//   XFER_LEN bytes of sprite attribute RAM into the object line-buffer logic
//   one byte per 6 MHz period, then hands the bus back.
//
// Ports
//   I_CLK_24M    system clock (only clock)
//   I_RESETn     asynchronous active-low reset
//   I_CEN6       6 MHz enable, one I_CLK_24M cycle wide, paces the copy
//   I_VBLKn      vertical blank, active low; its falling edge starts a copy
//   I_DMA_EN     DMA enable from the CPU control latch
//   I_BUSAKn     Z80 bus acknowledge, active low
//   I_RAM_D      CPU work RAM read data
//   O_BUSRQn     Z80 bus request, active low
//   O_RAM_A      CPU RAM read address
//   O_RAM_RDn    CPU RAM read strobe, active low
//   O_OBJDMA_A   destination byte index
//   O_OBJDMA_D   destination data
//   O_OBJDMA_CE  destination write strobe, one clock wide
//   O_BUSY       high from start until the bus has been released
//   O_LATE       sticky: vblank ended while the copy was still running
//
// Handshake: the bus is ours only while I_BUSAKn is low. O_RAM_RDn is low only
// while we own the bus; a byte is committed (O_OBJDMA_CE) only after its
// address has been presented with O_RAM_RDn low for a full I_CEN6 period.

module mario_obj_dma #(
    parameter logic [15:0] SRC_BASE = 16'h6900,
    parameter int          XFER_LEN = 384,
    parameter int          CNT_W    = 10
) (
    input  logic             I_CLK_24M,
    input  logic             I_RESETn,
    input  logic             I_CEN6,
    input  logic             I_VBLKn,
    input  logic             I_DMA_EN,
    input  logic             I_BUSAKn,
    input  logic [7:0]       I_RAM_D,
    output logic             O_BUSRQn,
    output logic [15:0]      O_RAM_A,
    output logic             O_RAM_RDn,
    output logic [CNT_W-1:0] O_OBJDMA_A,
    output logic [7:0]       O_OBJDMA_D,
    output logic             O_OBJDMA_CE,
    output logic             O_BUSY,
    output logic             O_LATE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    state_t           state_q;
    logic             vblk_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busrq_n_q;
    logic [15:0]      ram_a_q;
    logic             rd_n_q;
    logic [CNT_W-1:0] obj_a_q;
    logic [7:0]       obj_d_q;
    logic             obj_ce_q;
    logic             busy_q;
    logic             late_q;

    logic             start_d;
    logic [CNT_W-1:0] cnt_d;
    logic             last_byte;
    logic [15:0]      ram_a_d;

    assign start_d   = (state_q == ST_IDLE) && vblk_prev_q && !I_VBLKn && I_DMA_EN;
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign last_byte = (cnt_q == CNT_W'(XFER_LEN - 1));
    // 16-bit add, wraps modulo 2^16
    assign ram_a_d   = SRC_BASE + 16'(cnt_d);

    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state_q     <= ST_IDLE;
            vblk_prev_q <= 1'b1;
            cnt_q       <= '0;
            busrq_n_q   <= 1'b1;
            ram_a_q     <= SRC_BASE;
            rd_n_q      <= 1'b1;
            obj_a_q     <= '0;
            obj_d_q     <= 8'h00;
            obj_ce_q    <= 1'b0;
            busy_q      <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            vblk_prev_q <= I_VBLKn;
            obj_ce_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        state_q   <= ST_REQ;
                        busrq_n_q <= 1'b0;
                        busy_q    <= 1'b1;
                        late_q    <= 1'b0;
                        cnt_q     <= '0;
                        ram_a_q   <= SRC_BASE;
                    end
                end
                ST_REQ: begin
                    if (!I_DMA_EN) begin
                        // CPU withdrew the request before the bus was granted
                        state_q   <= ST_IDLE;
                        busrq_n_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else if (I_CEN6 && !I_BUSAKn) begin
                        state_q <= ST_XFER;
                        rd_n_q  <= 1'b0;
                        ram_a_q <= SRC_BASE + 16'(cnt_q);
                    end
                end
                ST_XFER: begin
                    if (I_VBLKn) begin
                        late_q <= 1'b1;
                    end
                    if (I_BUSAKn) begin
                        // Bus lost: stop reading, hold the counter
                        rd_n_q <= 1'b1;
                    end else if (I_CEN6) begin
                        if (rd_n_q) begin
                            // Bus regained: re-read the interrupted byte for a full period
                            rd_n_q <= 1'b0;
                        end else begin
                            obj_d_q  <= I_RAM_D;
                            obj_a_q  <= cnt_q;
                            obj_ce_q <= 1'b1;
                            cnt_q    <= cnt_d;
                            if (last_byte) begin
                                state_q   <= ST_REL;
                                busrq_n_q <= 1'b1;
                                rd_n_q    <= 1'b1;
                            end else begin
                                ram_a_q <= ram_a_d;
                            end
                        end
                    end
                end
                ST_REL: begin
                    if (I_BUSAKn) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign O_BUSRQn    = busrq_n_q;
    assign O_RAM_A     = ram_a_q;
    assign O_RAM_RDn   = rd_n_q;
    assign O_OBJDMA_A  = obj_a_q;
    assign O_OBJDMA_D  = obj_d_q;
    assign O_OBJDMA_CE = obj_ce_q;
    assign O_BUSY      = busy_q;
    assign O_LATE      = late_q;

endmodule

// File: tb/tb_mario_obj_dma.sv
// Directed bench for mario_obj_dma: normal copy, DMA disabled, bus loss,
// late completion, asynchronous reset mid-copy and withdrawal in REQ.
module tb_mario_obj_dma;
  localparam int XLEN = 384;

  logic       clk;
  logic       rst_n;
  logic       cen6;
  logic       vblk_n;
  logic       dma_en;
  logic       busak_n;
  logic [7:0] ram_d;
  logic       busrq_n;
  logic [15:0] ram_a;
  logic       ram_rd_n;
  logic [9:0] obj_a;
  logic [7:0] obj_d;
  logic       obj_ce;
  logic       busy;
  logic       late;

  mario_obj_dma dut (
    .I_CLK_24M  (clk),
    .I_RESETn   (rst_n),
    .I_CEN6     (cen6),
    .I_VBLKn    (vblk_n),
    .I_DMA_EN   (dma_en),
    .I_BUSAKn   (busak_n),
    .I_RAM_D    (ram_d),
    .O_BUSRQn   (busrq_n),
    .O_RAM_A    (ram_a),
    .O_RAM_RDn  (ram_rd_n),
    .O_OBJDMA_A (obj_a),
    .O_OBJDMA_D (obj_d),
    .O_OBJDMA_CE(obj_ce),
    .O_BUSY     (busy),
    .O_LATE     (late)
  );

  // RAM model: byte = low address bits
  assign ram_d = ram_a[7:0];

  // ---------------- clock / reset / enables ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : cen_gen
    logic [1:0] div;
    div  = 2'd0;
    cen6 = 1'b0;
    forever begin
      @(negedge clk);
      div  = div + 2'd1;
      cen6 = (div == 2'd0);
    end
  end

  // Bus model: ack 8 clocks (2 CEN6 periods) after request; release on drop
  logic force_release;
  initial begin : bus_model
    int rq_clks;
    rq_clks = 0;
    busak_n = 1'b1;
    forever begin
      @(negedge clk);
      if (busrq_n) begin
        rq_clks = 0;
        busak_n = 1'b1;
      end else begin
        if (rq_clks < 8) rq_clks++;
        busak_n = (force_release || rq_clks < 8) ? 1'b1 : 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];   // {index, data}
  int          ce_cnt;
  int          seq_err;
  logic        seen_rd;
  logic        busrq_seen;
  logic [15:0] first_rd_a;
  logic [15:0] last_rd_a;
  logic [7:0]  d100;
  int          n_checks;
  int          n_err;

  initial begin
    ce_cnt = 0; seq_err = 0; seen_rd = 1'b0; busrq_seen = 1'b0;
    first_rd_a = 16'h0; last_rd_a = 16'h0; d100 = 8'h0;
    n_checks = 0; n_err = 0;
  end

  always @(posedge clk) begin
    #1;
    if (obj_ce === 1'b1) begin
      if (exp_q.size() == 0) begin
        seq_err++;
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({obj_a, obj_d} !== e) seq_err++;
      end
      if (ce_cnt == 100) d100 = obj_d;
      ce_cnt++;
    end
    if (ram_rd_n === 1'b0) begin
      if (!seen_rd) first_rd_a = ram_a;
      seen_rd   = 1'b1;
      last_rd_a = ram_a;
    end
    if (busrq_n === 1'b0) busrq_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    ce_cnt = 0; seq_err = 0; seen_rd = 1'b0; busrq_seen = 1'b0;
    d100 = 8'h0;
    exp_q.delete();
  endtask

  task automatic fill_exp();
    for (int i = 0; i < XLEN; i++) begin
      logic [15:0] a;
      a = 16'h6900 + 16'(i);
      exp_q.push_back({10'(i), a[7:0]});
    end
  endtask

  task automatic wait_ce(input int n, input string tag);
    int k;
    k = 0;
    while (ce_cnt < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (ce_cnt < n) chk(tag, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) chk(tag, 0, 1);
  endtask

  task automatic vblank_fall();
    vblk_n = 1'b1;
    repeat (3) @(negedge clk);
    vblk_n = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; vblk_n = 1'b1; dma_en = 1'b0; force_release = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_busrq_n", busrq_n, 1);
    chk("rst_rd_n",    ram_rd_n, 1);
    chk("rst_ram_a",   ram_a, 32'h6900);
    chk("rst_obj_a",   obj_a, 0);
    chk("rst_obj_d",   obj_d, 0);
    chk("rst_obj_ce",  obj_ce, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_late",    late, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal transfer
    clr_mon(); fill_exp();
    dma_en = 1'b1;
    vblank_fall();
    chk("norm_busy_start", busy, 1);
    chk("norm_busrq_low",  busrq_n, 0);
    wait_idle("norm_timeout");
    chk("norm_busak_at_idle", busak_n, 1);
    chk("norm_ce_count",  ce_cnt, XLEN);
    chk("norm_seq_err",   seq_err, 0);
    chk("norm_exp_left",  exp_q.size(), 0);
    chk("norm_first_a",   first_rd_a, 32'h6900);
    chk("norm_last_a",    last_rd_a, 32'h6A7F);
    chk("norm_busrq_rel", busrq_n, 1);
    chk("norm_late",      late, 0);

    // DMA disabled at the vblank edge
    clr_mon();
    dma_en = 1'b0;
    vblank_fall();
    repeat (50) @(negedge clk);
    chk("dis_busrq_seen", busrq_seen, 0);
    chk("dis_ce_count",   ce_cnt, 0);
    chk("dis_busy",       busy, 0);

    // Bus loss while byte 100 is being read
    clr_mon(); fill_exp();
    dma_en = 1'b1;
    vblank_fall();
    wait_ce(100, "loss_wait_timeout");
    force_release = 1'b1;
    repeat (40) @(negedge clk);
    chk("loss_gap_ce",   ce_cnt, 100);
    chk("loss_gap_rd_n", ram_rd_n, 1);
    force_release = 1'b0;
    wait_idle("loss_timeout");
    chk("loss_ce_count", ce_cnt, XLEN);
    chk("loss_seq_err",  seq_err, 0);
    chk("loss_byte100",  d100, 32'h64);
    chk("loss_late",     late, 0);

    // Late completion, DMA_EN dropped mid-copy is ignored
    clr_mon(); fill_exp();
    vblank_fall();
    wait_ce(200, "late_wait_timeout");
    vblk_n = 1'b1;
    dma_en = 1'b0;
    wait_idle("late_timeout");
    chk("late_flag",     late, 1);
    chk("late_ce_count", ce_cnt, XLEN);
    chk("late_seq_err",  seq_err, 0);

    // Next start clears O_LATE; reset asynchronously at byte 50
    clr_mon(); fill_exp();
    dma_en = 1'b1;
    vblank_fall();
    chk("late_cleared", late, 0);
    chk("rst2_busy",    busy, 1);
    wait_ce(50, "rst2_wait_timeout");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_busrq_n", busrq_n, 1);
    chk("rst2_obj_ce",  obj_ce, 0);
    chk("rst2_busy",    busy, 0);
    vblk_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clr_mon();
    repeat (60) @(negedge clk);
    chk("rst2_quiet_busrq", busrq_seen, 0);
    chk("rst2_quiet_ce",    ce_cnt, 0);
    chk("rst2_quiet_busy",  busy, 0);

    // Withdraw in REQ before the ack arrives
    clr_mon();
    vblank_fall();
    chk("wd_busy_start",  busy, 1);
    chk("wd_busrq_low",   busrq_n, 0);
    @(negedge clk);
    dma_en = 1'b0;
    @(negedge clk);
    chk("wd_busrq_n",  busrq_n, 1);
    chk("wd_busy",     busy, 0);
    repeat (20) @(negedge clk);
    chk("wd_ce_count", ce_cnt, 0);
    chk("wd_rd_seen",  seen_rd, 0);
    chk("wd_idle_busrq", busrq_n, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
